// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory bus arbiter.
// Holds the FSM state encoding, the requester ids and the size defaults.
package mem_arbiter_pkg;

  localparam int WORD_SIZE_DEF      = 16;
  localparam int TIMEOUT_CYCLES_DEF = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    LD_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LD = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus-wait watchdog: cleared by load, counts enabled cycles, and flags
// the LIMIT-th enabled cycle so the arbiter can abandon that access.
module mem_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  assign expired = enable && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory read bus between fetch and load.
// Optional bus-wait timeout is compiled in with the MEM_TIMEOUT_EN macro.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE      = WORD_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  input  logic                 ld_req,
  input  logic [WORD_SIZE-1:0] ld_addr,
  output logic                 if_gnt,
  output logic                 ld_gnt,
  output logic                 if_done,
  output logic                 ld_done,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic                 bus_err
);

  arb_state_t state, next_state;
  req_id_t    last_grant;
  logic       if_pending, ld_pending;
  logic       grant_if, grant_ld, complete;

  // A requester sees its done one cycle late, so its still-high request
  // during the done cycle must not start a second access.
  assign if_pending = if_req & ~if_done;
  assign ld_pending = ld_req & ~ld_done;

  assign readM  = (state != IDLE);
  assign if_gnt = (state == IF_BUSY);
  assign ld_gnt = (state == LD_BUSY);

`ifdef MEM_TIMEOUT_EN
  logic expired, timeout;

  mem_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (grant_if | grant_ld),
    .enable (readM),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout;
    end
  end
`else
  // Keeps the timeout parameter referenced when the watchdog is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    next_state = state;
    grant_if   = 1'b0;
    grant_ld   = 1'b0;
    complete   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timeout    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (if_pending && (!ld_pending || last_grant == REQ_LD)) begin
          next_state = IF_BUSY;
          grant_if   = 1'b1;
        end else if (ld_pending) begin
          next_state = LD_BUSY;
          grant_ld   = 1'b1;
        end
      end
      IF_BUSY, LD_BUSY: begin
        if (inputReady) begin
          next_state = IDLE;
          complete   = 1'b1;
`ifdef MEM_TIMEOUT_EN
        end else if (expired) begin
          next_state = IDLE;
          timeout    = 1'b1;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= REQ_LD;
      address    <= '0;
      rdata      <= '0;
      if_done    <= 1'b0;
      ld_done    <= 1'b0;
    end else begin
      state   <= next_state;
      if_done <= complete && (state == IF_BUSY);
      ld_done <= complete && (state == LD_BUSY);
      if (grant_if) begin
        address    <= if_addr;
        last_grant <= REQ_IF;
      end else if (grant_ld) begin
        address    <= ld_addr;
        last_grant <= REQ_LD;
      end
      if (complete) begin
        rdata <= data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout expectations follow
// whether MEM_TIMEOUT_EN is defined for the build.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req, ld_req;
  logic [15:0] if_addr, ld_addr;
  logic        if_gnt, ld_gnt, if_done, ld_done;
  logic [15:0] rdata, address, data;
  logic        readM, inputReady, bus_err;

  int total  = 0;
  int passed = 0;

  mem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .if_gnt    (if_gnt),
    .ld_gnt    (ld_gnt),
    .if_done   (if_done),
    .ld_done   (ld_done),
    .rdata     (rdata),
    .readM     (readM),
    .address   (address),
    .data      (data),
    .inputReady(inputReady),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_b({tag, "_readM"}, readM, 1'b0);
    chk_w({tag, "_address"}, address, 16'h0000);
    chk_w({tag, "_rdata"}, rdata, 16'h0000);
    chk_b({tag, "_if_gnt"}, if_gnt, 1'b0);
    chk_b({tag, "_ld_gnt"}, ld_gnt, 1'b0);
    chk_b({tag, "_if_done"}, if_done, 1'b0);
    chk_b({tag, "_ld_done"}, ld_done, 1'b0);
    chk_b({tag, "_bus_err"}, bus_err, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; if_req = 1'b0; ld_req = 1'b0;
    if_addr = '0; ld_addr = '0; data = '0; inputReady = 1'b0;
    #2;
    chk_all_zero("reset");
    tick(); tick();
    reset_n = 1'b1;

    // Single fetch, ready in the first busy cycle
    if_req = 1'b1; if_addr = 16'h0010; data = 16'h6C01;
    tick();
    chk_b("t1_readM_c1", readM, 1'b1);
    chk_w("t1_addr_c1", address, 16'h0010);
    chk_b("t1_gnt_c1", if_gnt, 1'b1);
    chk_b("t1_done_c1", if_done, 1'b0);
    inputReady = 1'b1;
    tick();
    chk_b("t1_readM_c2", readM, 1'b0);
    chk_b("t1_done_c2", if_done, 1'b1);
    chk_w("t1_rdata_c2", rdata, 16'h6C01);
    chk_b("t1_gnt_c2", if_gnt, 1'b0);
    if_req = 1'b0; inputReady = 1'b0;
    tick();
    chk_b("t1_done_c3", if_done, 1'b0);
    chk_b("t1_readM_c3", readM, 1'b0);

    // Simultaneous requests right after reset: IF, then LD, then IF again
    reset_n = 1'b0; #1; reset_n = 1'b1;
    chk_w("t2_rdata_rst", rdata, 16'h0000);
    if_req = 1'b1; ld_req = 1'b1; if_addr = 16'h0100; ld_addr = 16'h0200; data = 16'h1111;
    tick();
    chk_b("t2_if_gnt_a", if_gnt, 1'b1);
    chk_b("t2_ld_gnt_a", ld_gnt, 1'b0);
    chk_w("t2_addr_a", address, 16'h0100);
    inputReady = 1'b1;
    tick();
    chk_b("t2_if_done", if_done, 1'b1);
    chk_w("t2_rdata_a", rdata, 16'h1111);
    chk_b("t2_ld_gnt_wait", ld_gnt, 1'b0);
    if_req = 1'b0; inputReady = 1'b0; data = 16'h2222;
    tick();
    chk_b("t2_ld_gnt_b", ld_gnt, 1'b1);
    chk_w("t2_addr_b", address, 16'h0200);
    chk_b("t2_readM_b", readM, 1'b1);
    inputReady = 1'b1;
    tick();
    chk_b("t2_ld_done", ld_done, 1'b1);
    chk_w("t2_rdata_b", rdata, 16'h2222);
    ld_req = 1'b0; inputReady = 1'b0;
    tick();
    chk_b("t2_idle_readM", readM, 1'b0);
    if_req = 1'b1; ld_req = 1'b1; data = 16'h3333;
    tick();
    chk_b("t2_if_gnt_c", if_gnt, 1'b1);
    chk_b("t2_ld_gnt_c", ld_gnt, 1'b0);
    chk_w("t2_addr_c", address, 16'h0100);
    inputReady = 1'b1;
    tick();
    chk_b("t2_if_done_c", if_done, 1'b1);
    if_req = 1'b0; inputReady = 1'b0;
    tick();
    chk_b("t2_ld_gnt_d", ld_gnt, 1'b1);
    inputReady = 1'b1;
    tick();
    chk_b("t2_ld_done_d", ld_done, 1'b1);
    ld_req = 1'b0; inputReady = 1'b0;
    tick();

    // Load with ready delayed to the fifth busy cycle; inputs wiggle meanwhile
    data = 16'h0BAD; ld_req = 1'b1; ld_addr = 16'h0ABC;
    tick();
    for (int c = 1; c <= 5; c++) begin
      chk_b("t3_readM", readM, 1'b1);
      chk_w("t3_addr", address, 16'h0ABC);
      chk_b("t3_ld_done", ld_done, 1'b0);
      if (c == 2) begin ld_addr = 16'hFFFF; if_req = 1'b1; if_addr = 16'h1234; end
      if (c == 4) if_req = 1'b0;
      if (c == 5) begin data = 16'h5A5A; inputReady = 1'b1; end
      tick();
    end
    chk_b("t3_done", ld_done, 1'b1);
    chk_w("t3_rdata", rdata, 16'h5A5A);
    chk_b("t3_readM_end", readM, 1'b0);
    ld_req = 1'b0; inputReady = 1'b0;
    tick();
    chk_b("t3_single_done", ld_done, 1'b0);
    inputReady = 1'b1; data = 16'hDEAD;
    tick();
    chk_w("idle_ready_rdata", rdata, 16'h5A5A);
    chk_b("idle_ready_if_done", if_done, 1'b0);
    chk_b("idle_ready_ld_done", ld_done, 1'b0);
    chk_b("idle_ready_readM", readM, 1'b0);
    inputReady = 1'b0;

    // Fetch request dropped one cycle after grant
    if_req = 1'b1; if_addr = 16'h0030; data = 16'h7777;
    tick();
    chk_b("t4_gnt_c1", if_gnt, 1'b1);
    if_req = 1'b0;
    tick();
    chk_b("t4_readM_c2", readM, 1'b1);
    chk_b("t4_gnt_c2", if_gnt, 1'b1);
    chk_w("t4_addr_c2", address, 16'h0030);
    inputReady = 1'b1;
    tick();
    chk_b("t4_done", if_done, 1'b1);
    chk_w("t4_rdata", rdata, 16'h7777);
    inputReady = 1'b0;
    tick();
    chk_b("t4_done_end", if_done, 1'b0);
    chk_b("t4_readM_end", readM, 1'b0);

    // Asynchronous reset in the middle of a load
    ld_req = 1'b1; ld_addr = 16'h0040; data = 16'h4444;
    tick();
    chk_b("t5_ld_gnt", ld_gnt, 1'b1);
    chk_b("t5_readM", readM, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    inputReady = 1'b1;
    tick();
    ld_req = 1'b0; inputReady = 1'b0; reset_n = 1'b1;
    tick();
    chk_b("t5_no_done_a", ld_done, 1'b0);
    chk_w("t5_rdata", rdata, 16'h0000);
    chk_b("t5_readM_post", readM, 1'b0);
    tick();
    chk_b("t5_no_done_b", ld_done, 1'b0);

    // Memory never answers
    if_req = 1'b1; if_addr = 16'h0060; data = 16'h3C3C;
    tick();
    inputReady = 1'b1;
    tick();
    chk_w("t6_rdata_pre", rdata, 16'h3C3C);
    if_req = 1'b0; inputReady = 1'b0;
    tick();
    ld_req = 1'b1; ld_addr = 16'h0050; data = 16'hBEEF;
    tick();
`ifdef MEM_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      chk_b("t6_readM", readM, 1'b1);
      chk_b("t6_bus_err_wait", bus_err, 1'b0);
      chk_w("t6_addr", address, 16'h0050);
      if (c == 15) ld_req = 1'b0;
      tick();
    end
    chk_b("t6_bus_err", bus_err, 1'b1);
    chk_b("t6_readM_idle", readM, 1'b0);
    chk_b("t6_ld_gnt_idle", ld_gnt, 1'b0);
    chk_b("t6_no_done", ld_done, 1'b0);
    chk_w("t6_rdata_kept", rdata, 16'h3C3C);
    tick();
    chk_b("t6_bus_err_pulse", bus_err, 1'b0);
    chk_b("t6_readM_after", readM, 1'b0);
`else
    for (int c = 1; c <= 20; c++) begin
      chk_b("t6_readM_hold", readM, 1'b1);
      chk_b("t6_bus_err_tied", bus_err, 1'b0);
      tick();
    end
    chk_b("t6_no_done", ld_done, 1'b0);
    chk_w("t6_rdata_kept", rdata, 16'h3C3C);
    ld_req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_b("t6_readM_reset", readM, 1'b0);
    reset_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
